// File: rtl/execute_alu_stage_if.sv
// Execute-to-memory bus: decoded execute fields in, registered memory fields out.
// The stage sits on the slave modport; the upstream/driver side uses master.
interface execute_alu_stage_if;
  logic        flush_execute;
  logic        wre_execute;
  logic        vector_wre_execute;
  logic        write_memory_enable_execute;
  logic [1:0]  select_writeback_data_mux_execute;
  logic [3:0]  aluOp_execute;
  logic [15:0] srcA_out;
  logic [15:0] srcB_out;
  logic [3:0]  rd_execute;
  logic        stall_execute;
  logic        wre_memory;
  logic        vector_wre_memory;
  logic        write_memory_enable_memory;
  logic [1:0]  select_writeback_data_mux_memory;
  logic [3:0]  rd_memory;
  logic [15:0] alu_result_memory;
  logic [15:0] write_data_memory;

  modport master (
    output flush_execute, wre_execute, vector_wre_execute,
    output write_memory_enable_execute,
    output select_writeback_data_mux_execute,
    output aluOp_execute, srcA_out, srcB_out, rd_execute,
    input  stall_execute, wre_memory, vector_wre_memory,
    input  write_memory_enable_memory,
    input  select_writeback_data_mux_memory,
    input  rd_memory, alu_result_memory, write_data_memory
  );

  modport slave (
    input  flush_execute, wre_execute, vector_wre_execute,
    input  write_memory_enable_execute,
    input  select_writeback_data_mux_execute,
    input  aluOp_execute, srcA_out, srcB_out, rd_execute,
    output stall_execute, wre_memory, vector_wre_memory,
    output write_memory_enable_memory,
    output select_writeback_data_mux_memory,
    output rd_memory, alu_result_memory, write_data_memory
  );
endinterface

// File: rtl/execute_alu_stage.sv
// Execute ALU stage with EX/MEM register; EXEC_MUL_EN enables the
// 16-step shift-add multiplier FSM (otherwise aluOp 7 yields 0).
module execute_alu_stage (
  input logic clk,
  input logic reset,
  execute_alu_stage_if.slave bus
);
  typedef struct packed {
    logic        wre;
    logic        vwre;
    logic        wme;
    logic [1:0]  sel;
    logic [3:0]  rd;
    logic [15:0] alu;
    logic [15:0] wdata;
  } ex_mem_t;

  logic [15:0] a, b, alu_res;
  ex_mem_t     issue, bubble, mem_q, mem_d;
  logic        stall;

  assign a = bus.srcA_out;
  assign b = bus.srcB_out;

  always_comb begin
    alu_res = '0;
    case (bus.aluOp_execute)
      4'd0: alu_res = a + b;
      4'd1: alu_res = a - b;
      4'd2: alu_res = a & b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = a ^ b;
      4'd5: alu_res = a << b[3:0];
      4'd6: alu_res = a >> b[3:0];
      4'd8: alu_res = b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    issue.wre   = bus.wre_execute;
    issue.vwre  = bus.vector_wre_execute;
    issue.wme   = bus.write_memory_enable_execute;
    issue.sel   = bus.select_writeback_data_mux_execute;
    issue.rd    = bus.rd_execute;
    issue.alu   = alu_res;
    issue.wdata = b;
  end

  // A bubble clears enables and rd but leaves the data fields untouched.
  always_comb begin
    bubble      = mem_q;
    bubble.wre  = 1'b0;
    bubble.vwre = 1'b0;
    bubble.wme  = 1'b0;
    bubble.rd   = '0;
  end

`ifdef EXEC_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  ex_mem_t     ctl_q, ctl_d;
  logic [15:0] acc_step;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 16'h0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    ctl_d    = ctl_q;
    mem_d    = issue;
    stall    = 1'b0;
    if (bus.flush_execute) begin
      state_d = IDLE;
      cnt_d   = '0;
      mem_d   = bubble;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.aluOp_execute == 4'd7) begin
            stall     = 1'b1;
            ctl_d     = issue;
            ctl_d.alu = '0;
            mcand_d   = b;
            mplier_d  = a;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = BUSY;
            mem_d     = bubble;
          end
        end
        BUSY: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            mem_d     = ctl_q;
            mem_d.alu = acc_step;
            state_d   = IDLE;
          end else begin
            stall = 1'b1;
            mem_d = bubble;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ctl_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      ctl_q    <= ctl_d;
    end
  end
`else
  always_comb begin
    stall = 1'b0;
    mem_d = bus.flush_execute ? bubble : issue;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  // Stall must drop as soon as reset is asserted, even with aluOp 7 present.
  assign bus.stall_execute = reset & stall;

  assign bus.wre_memory                       = mem_q.wre;
  assign bus.vector_wre_memory                = mem_q.vwre;
  assign bus.write_memory_enable_memory       = mem_q.wme;
  assign bus.select_writeback_data_mux_memory = mem_q.sel;
  assign bus.rd_memory                        = mem_q.rd;
  assign bus.alu_result_memory                = mem_q.alu;
  assign bus.write_data_memory                = mem_q.wdata;
endmodule

// File: tb/tb_execute_alu_stage.sv
// Randomized and directed bench for execute_alu_stage against a
// behavioural model; builds with or without EXEC_MUL_EN.
module tb_execute_alu_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_run = 0;
  int   n_fail = 0;

  execute_alu_stage_if bus();

  execute_alu_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference memory-stage contents
  logic        m_wre, m_vwre, m_wme;
  logic [1:0]  m_sel;
  logic [3:0]  m_rd;
  logic [15:0] m_res, m_wd;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(int op, int a, int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * (1 << (b % 16));
      6: r = a / (1 << (b % 16));
      8: r = b;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [63:0] obs_all();
    return {23'd0, bus.wre_memory, bus.vector_wre_memory,
            bus.write_memory_enable_memory,
            bus.select_writeback_data_mux_memory, bus.rd_memory,
            bus.alu_result_memory, bus.write_data_memory};
  endfunction

  function automatic logic [63:0] exp_all();
    return {23'd0, m_wre, m_vwre, m_wme, m_sel, m_rd, m_res, m_wd};
  endfunction

  task automatic set_in(int op, int a, int b, int rd, bit wre,
                        bit vwre, bit wme, int sel, bit fl);
    bus.aluOp_execute                     = 4'(op);
    bus.srcA_out                          = 16'(a);
    bus.srcB_out                          = 16'(b);
    bus.rd_execute                        = 4'(rd);
    bus.wre_execute                       = wre;
    bus.vector_wre_execute                = vwre;
    bus.write_memory_enable_execute       = wme;
    bus.select_writeback_data_mux_execute = 2'(sel);
    bus.flush_execute                     = fl;
  endtask

  task automatic rand_in(bit fl);
    set_in($urandom_range(0, 15), $urandom_range(0, 65535),
           $urandom_range(0, 65535), $urandom_range(0, 15),
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3), fl);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge();
    if (bus.flush_execute) begin
      m_wre = 0; m_vwre = 0; m_wme = 0; m_rd = 0;
    end else begin
      m_wre  = bus.wre_execute;
      m_vwre = bus.vector_wre_execute;
      m_wme  = bus.write_memory_enable_execute;
      m_sel  = bus.select_writeback_data_mux_execute;
      m_rd   = bus.rd_execute;
      m_res  = ref_alu(int'(bus.aluOp_execute), int'(bus.srcA_out),
                       int'(bus.srcB_out));
      m_wd   = bus.srcB_out;
    end
  endtask

  task automatic chk_bubble(string tag);
    chk(tag, {bus.wre_memory, bus.vector_wre_memory,
              bus.write_memory_enable_memory, bus.rd_memory}, 0);
  endtask

  initial begin
    int stalls, bubbles, op;
    bit fl;
    reset = 1'b0;
    set_in(7, 7, 9, 1, 1, 1, 1, 3, 0);
    #3;
    chk("reset_out", obs_all(), 0);
    chk("reset_stall", bus.stall_execute, 0);
    m_wre = 0; m_vwre = 0; m_wme = 0; m_sel = 0;
    m_rd = 0; m_res = 0; m_wd = 0;
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    chk("idle_out", obs_all(), 0);

    for (int i = 0; i < 300; i++) begin
      fl = ($urandom_range(0, 7) == 0);
      rand_in(fl);
`ifdef EXEC_MUL_EN
      if (bus.aluOp_execute == 4'd7 && !fl) bus.aluOp_execute = 4'd2;
`endif
      #1;
      chk("rand_stall", bus.stall_execute, 0);
      model_edge();
      step();
      chk("rand_out", obs_all(), exp_all());
    end

    set_in(0, 16'hFFFF, 2, 3, 1, 0, 0, 0, 0);
    step();
    chk("add_res", bus.alu_result_memory, 16'h0001);
    chk("add_wre", bus.wre_memory, 1);
    chk("add_rd", bus.rd_memory, 3);
    set_in(5, 1, 16'h0013, 2, 1, 0, 0, 0, 0);
    step();
    chk("sll_res", bus.alu_result_memory, 16'h0008);
    set_in(6, 16'h8000, 4, 2, 1, 0, 0, 0, 0);
    step();
    chk("srl_res", bus.alu_result_memory, 16'h0800);

`ifdef EXEC_MUL_EN
    set_in(7, 16'h0123, 16'h0045, 5, 1, 0, 0, 2, 0);
    stalls = 0;
    bubbles = 0;
    for (int i = 0; i < 17; i++) begin
      chk("mul_stall", bus.stall_execute, (i < 16) ? 1 : 0);
      if (bus.stall_execute) stalls++;
      step();
      if (i < 16) begin
        if (!bus.wre_memory && !bus.vector_wre_memory &&
            !bus.write_memory_enable_memory && bus.rd_memory == 0)
          bubbles++;
        rand_in(0);
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mul_nstall", stalls, 16);
    chk("mul_nbub", bubbles, 16);
    chk("mul_res", bus.alu_result_memory, 16'h4E6F);
    chk("mul_rd", bus.rd_memory, 5);
    chk("mul_wre", bus.wre_memory, 1);
    chk("mul_en", {bus.vector_wre_memory,
                   bus.write_memory_enable_memory}, 0);

    set_in(7, 16'h0123, 16'h0045, 5, 1, 0, 0, 2, 0);
    step();
    for (int i = 0; i < 7; i++) begin
      rand_in(0);
      step();
    end
    chk("fl_busy", bus.stall_execute, 1);
    set_in(7, 3, 3, 6, 1, 1, 1, 1, 1);
    #1;
    chk("fl_stall", bus.stall_execute, 0);
    step();
    chk_bubble("fl_bubble");
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 65535);
      set_in(0, op, 7, 2, 1, 0, 0, 0, 0);
      #1;
      chk("fl_idle", bus.stall_execute, 0);
      step();
      chk("fl_noprod", bus.alu_result_memory, ref_alu(0, op, 7));
    end

    set_in(7, 16'h0123, 16'h0045, 5, 1, 0, 0, 2, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      rand_in(0);
      step();
    end
    bus.aluOp_execute = 4'd7;
`else
    set_in(7, 7, 9, 4, 1, 0, 0, 0, 0);
    #1;
    chk("nomul_stall0", bus.stall_execute, 0);
    step();
    chk("nomul_res", bus.alu_result_memory, 0);
    chk("nomul_wre", bus.wre_memory, 1);
    chk("nomul_rd", bus.rd_memory, 4);
    chk("nomul_stall1", bus.stall_execute, 0);
    set_in(7, 16'h1234, 16'h0005, 9, 1, 1, 1, 3, 0);
    step();
`endif
    #1;
    reset = 1'b0;
    #1;
    chk("rst_out", obs_all(), 0);
    chk("rst_stall", bus.stall_execute, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", obs_all(), 0);
    reset = 1'b1;
    set_in(0, 2, 3, 1, 1, 0, 0, 0, 0);
    #1;
    chk("post_stall", bus.stall_execute, 0);
    step();
    chk("post_add", bus.alu_result_memory, 5);
    chk("post_wre", bus.wre_memory, 1);
    chk("post_rd", bus.rd_memory, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
